// File: rtl/reg_exec_unit.sv
// reg_exec_unit: two 8-bit registers (A, B) loaded from switches or, once per
// Execute assertion, from an external router driven by A/B/R_Lat.
// IDLE -> EXEC (latch R) -> HOLD (wait for Execute low) -> IDLE.
// Optional macro EXEC_COUNT_EN adds a wrapping pass counter on ExecCount.
module reg_exec_unit (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       LoadA,
  input  logic       LoadB,
  input  logic       Execute,
  input  logic [7:0] Din,
  input  logic [1:0] R,
  input  logic [7:0] A_Route,
  input  logic [7:0] B_Route,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [1:0] R_Lat,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] ExecCount
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_t;

  state_t st, st_nxt;
  logic   ld_a, ld_b, cap, lat_r, clr_r;

  // state register
  always_ff @(posedge Clk) begin
    if (Reset) st <= IDLE;
    else       st <= st_nxt;
  end

  // next state and per-edge register controls; Execute beats switch loads in IDLE
  always_comb begin
    st_nxt = st;
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    cap    = 1'b0;
    lat_r  = 1'b0;
    clr_r  = 1'b0;
    case (st)
      IDLE: begin
        if (Execute) begin
          st_nxt = EXEC;
          lat_r  = 1'b1;
        end else begin
          ld_a  = LoadA;
          ld_b  = LoadB;
          clr_r = 1'b1;
        end
      end
      EXEC: begin
        cap    = 1'b1;
        st_nxt = HOLD;
      end
      HOLD: begin
        if (!Execute) begin
          st_nxt = IDLE;
          clr_r  = 1'b1;
        end
      end
      default: begin
        st_nxt = IDLE;
        clr_r  = 1'b1;
      end
    endcase
  end

  // A/B: switch loads in IDLE, single router capture on leaving EXEC
  always_ff @(posedge Clk) begin
    if (Reset) begin
      A <= 8'h00;
      B <= 8'h00;
    end else if (cap) begin
      A <= A_Route;
      B <= B_Route;
    end else begin
      if (ld_a) A <= Din;
      if (ld_b) B <= Din;
    end
  end

  // routing select: captured on IDLE->EXEC, frozen through the pass, 00 in IDLE
  always_ff @(posedge Clk) begin
    if (Reset)      R_Lat <= 2'b00;
    else if (lat_r) R_Lat <= R;
    else if (clr_r) R_Lat <= 2'b00;
  end

  assign Busy = (st == EXEC) || (st == HOLD);
  assign Done = (st == HOLD);

`ifdef EXEC_COUNT_EN
  logic [7:0] cnt;

  // completed-pass counter, wraps naturally at 8 bits
  always_ff @(posedge Clk) begin
    if (Reset)    cnt <= 8'h00;
    else if (cap) cnt <= cnt + 8'd1;
  end

  assign ExecCount = cnt;
`else
  assign ExecCount = 8'h00;
`endif

endmodule

// File: tb/tb_reg_exec_unit.sv
// Bench for reg_exec_unit: directed scenarios plus random traffic, compared
// cycle by cycle against a rule-level reference model.
module tb_reg_exec_unit;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       LoadA = 1'b0, LoadB = 1'b0, Execute = 1'b0;
  logic [7:0] Din = 8'h00;
  logic [1:0] R = 2'b00;
  logic [7:0] A_Route, B_Route;
  logic [7:0] A, B, ExecCount;
  logic [1:0] R_Lat;
  logic       Busy, Done;

  int checks = 0;
  int failures = 0;

  // reference model: phase 0 = idle, 1 = executing, 2 = holding
  int         m_ph = 0;
  logic [7:0] ma = 0, mb = 0, mcnt = 0;
  logic [1:0] mrl = 0;

  always #5 Clk = ~Clk;

  reg_exec_unit dut (
    .Clk(Clk), .Reset(Reset), .LoadA(LoadA), .LoadB(LoadB), .Execute(Execute),
    .Din(Din), .R(R), .A_Route(A_Route), .B_Route(B_Route),
    .A(A), .B(B), .R_Lat(R_Lat), .Busy(Busy), .Done(Done), .ExecCount(ExecCount)
  );

  // lab router: 00 pass, 01 copy A into B, 10 A=A+B, 11 swap
  function automatic logic [15:0] route(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b);
    case (sel)
      2'b00:   return {a, b};
      2'b01:   return {a, a};
      2'b10:   return {a + b, b};
      default: return {b, a};
    endcase
  endfunction

  logic [15:0] rt;
  assign rt      = route(R_Lat, A, B);
  assign A_Route = rt[15:8];
  assign B_Route = rt[7:0];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("A", A, ma);
    chk("B", B, mb);
    chk("R_Lat", {6'd0, R_Lat}, {6'd0, mrl});
    chk("Busy", {7'd0, Busy}, {7'd0, m_ph != 0});
    chk("Done", {7'd0, Done}, {7'd0, m_ph == 2});
`ifdef EXEC_COUNT_EN
    chk("ExecCount", ExecCount, mcnt);
`else
    chk("ExecCount", ExecCount, 8'h00);
`endif
  endtask

  // apply inputs, take one edge, advance the model, compare
  task automatic tick(input bit rst, input bit la, input bit lb, input bit ex,
                      input logic [7:0] din, input logic [1:0] r);
    logic [15:0] nr;
    Reset = rst; LoadA = la; LoadB = lb; Execute = ex; Din = din; R = r;
    @(posedge Clk);
    if (rst) begin
      m_ph = 0; ma = 0; mb = 0; mrl = 0; mcnt = 0;
    end else begin
      case (m_ph)
        0: if (ex) begin
             m_ph = 1; mrl = r;
           end else begin
             if (la) ma = din;
             if (lb) mb = din;
           end
        1: begin
             nr = route(mrl, ma, mb);
             ma = nr[15:8]; mb = nr[7:0];
             mcnt = mcnt + 8'd1;
             m_ph = 2;
           end
        default: if (!ex) begin
             m_ph = 0; mrl = 0;
           end
      endcase
    end
    #1;
    check_all();
  endtask

  initial begin
    // reset and switch loads
    tick(1, 0, 0, 0, 8'h00, 2'b00);
    chk("rst_A", A, 8'h00);
    tick(0, 1, 0, 0, 8'h3C, 2'b00);
    tick(0, 0, 1, 0, 8'hA5, 2'b00);
    chk("load_A", A, 8'h3C);
    chk("load_B", B, 8'hA5);
    chk("load_busy", {7'd0, Busy}, 8'h00);

    // swap with Execute held five cycles: exactly one swap
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 1, 8'h00, 2'b11);
      if (i == 1) begin
        chk("swap_A", A, 8'hA5);
        chk("swap_B", B, 8'h3C);
      end
    end
    chk("swap_done", {7'd0, Done}, 8'h01);
    chk("swap_once_A", A, 8'hA5);
    tick(0, 0, 0, 0, 8'h00, 2'b11);
    chk("swap_rlat_clr", {6'd0, R_Lat}, 8'h00);

    // R latched as 10, changed to 01 mid-pass
    tick(0, 0, 0, 1, 8'h00, 2'b10);
    tick(0, 0, 0, 1, 8'h00, 2'b01);
    tick(0, 0, 0, 1, 8'h00, 2'b01);
    chk("rhold_rlat", {6'd0, R_Lat}, 8'h02);
    chk("rhold_A", A, 8'hA5 + 8'h3C);
    chk("rhold_B", B, 8'h3C);
    tick(0, 0, 0, 0, 8'h00, 2'b00);

    // Execute beats LoadA on the same edge
    tick(0, 1, 0, 1, 8'hFF, 2'b00);
    chk("exwin_busy", {7'd0, Busy}, 8'h01);
    chk("exwin_A", A, 8'hE1);

    // reset while in EXEC discards the capture
    tick(1, 0, 0, 1, 8'h00, 2'b11);
    chk("rst_exec_A", A, 8'h00);
    chk("rst_exec_B", B, 8'h00);
    chk("rst_exec_busy", {7'd0, Busy}, 8'h00);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      tick(($urandom_range(0, 31) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 2) == 0), 8'($urandom), 2'($urandom));

    // 256 passes for the counter wrap
    tick(1, 0, 0, 0, 8'h00, 2'b00);
    for (int i = 0; i < 256; i++) begin
      tick(0, 0, 0, 1, 8'h00, 2'($urandom));
      tick(0, 0, 0, 1, 8'h00, 2'b00);
      tick(0, 0, 0, 0, 8'h00, 2'b00);
`ifdef EXEC_COUNT_EN
      if (i == 254) chk("cnt_ff", ExecCount, 8'hFF);
      if (i == 255) chk("cnt_wrap", ExecCount, 8'h00);
`else
      if (i == 254 || i == 255) chk("cnt_zero", ExecCount, 8'h00);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
